// File: rtl/bp_pkg.sv
// Shared bytepipe constants and arbiter state encoding.
package bp_pkg;

  localparam int BP_W          = 8;
  localparam int BP_CMD_WR_BIT = 7;
  localparam int BP_ADDR_W     = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    WRDATA = 2'd2,
    RDRESP = 2'd3
  } bp_state_e;

  function automatic logic bpIsWr(
    input logic [BP_W-1:0] cmd
  );
    return cmd[BP_CMD_WR_BIT];
  endfunction

endpackage

// File: rtl/bp_rr_pick.sv
// Onehot requester picker: round-robin from ptr, or fixed
// priority from index 0 when BP_REG_ARB_FIXED_PRIO_EN is defined.
module bp_rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx
);

  int               k;
  logic [PTR_W-1:0] kk;
  logic             found;

`ifdef BP_REG_ARB_FIXED_PRIO_EN
  logic ptrUnused;
  assign ptrUnused = ^ptr;
`endif

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef BP_REG_ARB_FIXED_PRIO_EN
      k = i;
`else
      // explicit wrap keeps non-power-of-two N_REQ correct
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
`endif
      kk = PTR_W'(k);
      if (!found && req[kk]) begin
        found   = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/bp_reg_arb.sv
// Transaction-level bytepipe arbiter in front of one register memory.
// BP_REG_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module bp_reg_arb
  import bp_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cg,
  input  logic [BP_W*N_REQ-1:0] i_req_bp_data,
  input  logic [N_REQ-1:0]      i_req_bp_valid,
  output logic [N_REQ-1:0]      o_req_bp_ready,
  output logic [BP_W-1:0]       o_req_bp_data,
  output logic [N_REQ-1:0]      o_req_bp_valid,
  input  logic [N_REQ-1:0]      i_req_bp_ready,
  output logic [BP_W-1:0]       o_mem_bp_data,
  output logic                  o_mem_bp_valid,
  input  logic                  i_mem_bp_ready,
  input  logic [BP_W-1:0]       i_mem_bp_data,
  input  logic                  i_mem_bp_valid,
  output logic                  o_mem_bp_ready,
  output logic [N_REQ-1:0]      o_grant
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  bp_state_e        state;
  logic [N_REQ-1:0] grant;
  logic [PTR_W-1:0] gIdx;
  logic [PTR_W-1:0] rrPtr;

  logic [N_REQ-1:0] pickGnt;
  logic [PTR_W-1:0] pickIdx;
  logic [BP_W-1:0]  gData;
  logic             gValid;
  logic             gRspRdy;
  logic             fwd;
  logic             rsp;
  logic             memHs;
  logic             rspHs;
  logic             done;

  bp_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) uPick (
    .req (i_req_bp_valid),
    .ptr (rrPtr),
    .gnt (pickGnt),
    .idx (pickIdx)
  );

  assign gData   = i_req_bp_data[int'(gIdx)*BP_W +: BP_W];
  assign gValid  = i_req_bp_valid[gIdx];
  assign gRspRdy = i_req_bp_ready[gIdx];

  assign fwd = i_cg && (state == CMD || state == WRDATA);
  assign rsp = i_cg && (state == RDRESP);

  assign o_mem_bp_valid = fwd && gValid;
  assign o_mem_bp_data  = fwd ? gData : '0;
  assign o_req_bp_ready = (fwd && i_mem_bp_ready) ? grant : '0;

  assign o_req_bp_data  = rsp ? i_mem_bp_data : '0;
  assign o_req_bp_valid = (rsp && i_mem_bp_valid) ? grant : '0;
  assign o_mem_bp_ready = rsp && gRspRdy;

  assign o_grant = grant;

  assign memHs = o_mem_bp_valid && i_mem_bp_ready;
  assign rspHs = rsp && i_mem_bp_valid && gRspRdy;
  assign done  = (state == WRDATA && memHs)
              || (state == RDRESP && rspHs);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      grant <= '0;
      gIdx  <= '0;
    end else if (i_cg) begin
      unique case (state)
        IDLE: begin
          if (|i_req_bp_valid) begin
            grant <= pickGnt;
            gIdx  <= pickIdx;
            state <= CMD;
          end
        end
        CMD: begin
          if (memHs)
            state <= bpIsWr(gData) ? WRDATA : RDRESP;
        end
        WRDATA, RDRESP: begin
          if (done) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BP_REG_ARB_FIXED_PRIO_EN
  assign rrPtr = '0;
`else
  logic [PTR_W-1:0] nextPtr;

  assign nextPtr = (int'(gIdx) == N_REQ - 1) ? '0 : gIdx + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      rrPtr <= '0;
    else if (i_cg && done)
      rrPtr <= nextPtr;
  end
`endif

endmodule

// File: tb/tb_bp_reg_arb.sv
// Directed bench for bp_reg_arb with five requesters.
module tb_bp_reg_arb;

  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rstN;
  logic           cg;
  logic [8*N-1:0] reqData;
  logic [N-1:0]   reqValid;
  logic [N-1:0]   reqReady;
  logic [7:0]     rspData;
  logic [N-1:0]   rspValid;
  logic [N-1:0]   rspRdy;
  logic [7:0]     memData;
  logic           memValid;
  logic           memRdy;
  logic [7:0]     memRd;
  logic           memRv;
  logic           memRready;
  logic [N-1:0]   grant;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bp_reg_arb #(
    .N_REQ (N)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_cg           (cg),
    .i_req_bp_data  (reqData),
    .i_req_bp_valid (reqValid),
    .o_req_bp_ready (reqReady),
    .o_req_bp_data  (rspData),
    .o_req_bp_valid (rspValid),
    .i_req_bp_ready (rspRdy),
    .o_mem_bp_data  (memData),
    .o_mem_bp_valid (memValid),
    .i_mem_bp_ready (memRdy),
    .i_mem_bp_data  (memRd),
    .i_mem_bp_valid (memRv),
    .o_mem_bp_ready (memRready),
    .o_grant        (grant)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN     = 1'b0;
    cg       = 1'b1;
    reqData  = '0;
    reqValid = '0;
    rspRdy   = '1;
    memRdy   = 1'b1;
    memRd    = 8'h00;
    memRv    = 1'b0;
    repeat (2) cyc();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_memvalid", 32'(memValid), 0);
    chk("rst_reqready", 32'(reqReady), 0);
    rstN = 1'b1;
    cyc();

    // single write from req0
    reqData[7:0] = 8'h85;
    reqValid     = 5'b00001;
    #1;
    chk("wr_idle_ready", 32'(reqReady), 0);
    chk("wr_idle_memvalid", 32'(memValid), 0);
    cyc();
    chk("wr_cmd_grant", 32'(grant), 1);
    chk("wr_cmd_data", 32'(memData), 'h85);
    chk("wr_cmd_ready", 32'(reqReady), 1);
    cyc();
    reqData[7:0] = 8'h3C;
    #1;
    chk("wr_dat_grant", 32'(grant), 1);
    chk("wr_dat_data", 32'(memData), 'h3C);
    chk("wr_dat_rspvalid", 32'(rspValid), 0);
    cyc();
    reqValid = '0;
    #1;
    chk("wr_end_grant", 32'(grant), 0);

    // read from req1, four-cycle memory latency
    reqData[15:8] = 8'h05;
    reqValid      = 5'b00010;
    cyc();
    chk("rd_cmd_grant", 32'(grant), 'h02);
    chk("rd_cmd_data", 32'(memData), 'h05);
    chk("rd_cmd_ready", 32'(reqReady), 'h02);
    cyc();
    reqValid = '0;
    #1;
    chk("rd_resp_memvalid", 32'(memValid), 0);
    repeat (2) cyc();
    chk("rd_wait_rspvalid", 32'(rspValid), 0);
    cyc();
    memRd = 8'h3C;
    memRv = 1'b1;
    #1;
    chk("rd_rspvalid", 32'(rspValid), 'h02);
    chk("rd_rspdata", 32'(rspData), 'h3C);
    chk("rd_memready", 32'(memRready), 1);
    cyc();
    memRv = 1'b0;
    #1;
    chk("rd_end_grant", 32'(grant), 0);

    // contention between req0 and req1 writes
    reqData[7:0]  = 8'h85;
    reqData[15:8] = 8'h85;
    reqValid      = 5'b00011;
    cyc();
    chk("ct_grant0", 32'(grant), 'h01);
    repeat (3) cyc();
`ifdef BP_REG_ARB_FIXED_PRIO_EN
    chk("ct_grant1", 32'(grant), 'h01);
`else
    chk("ct_grant1", 32'(grant), 'h02);
`endif
    repeat (3) cyc();
    chk("ct_grant2", 32'(grant), 'h01);
    repeat (2) cyc();
    reqValid = '0;
    #1;
    chk("ct_end_grant", 32'(grant), 0);

    // clock gate low while in WRDATA
    reqData[23:16] = 8'h8A;
    reqValid       = 5'b00100;
    cyc();
    chk("cg_cmd_grant", 32'(grant), 'h04);
    cyc();
    reqData[23:16] = 8'h55;
    cg             = 1'b0;
    #1;
    chk("cg_memvalid", 32'(memValid), 0);
    chk("cg_reqready", 32'(reqReady), 0);
    repeat (3) cyc();
    chk("cg_hold_grant", 32'(grant), 'h04);
    cg = 1'b1;
    #1;
    chk("cg_resume_valid", 32'(memValid), 1);
    chk("cg_resume_data", 32'(memData), 'h55);
    cyc();
    reqValid = '0;
    #1;
    chk("cg_end_grant", 32'(grant), 0);

    // read response backpressure on req3
    reqData[31:24] = 8'h12;
    reqValid       = 5'b01000;
    cyc();
    chk("bp_cmd_grant", 32'(grant), 'h08);
    cyc();
    reqValid = '0;
    memRd    = 8'h3C;
    memRv    = 1'b1;
    rspRdy   = 5'b10111;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_memready", 32'(memRready), 0);
      chk("bp_rspvalid", 32'(rspValid), 'h08);
      cyc();
    end
    rspRdy = '1;
    #1;
    chk("bp_release", 32'(memRready), 1);
    chk("bp_rspdata", 32'(rspData), 'h3C);
    cyc();
    memRv = 1'b0;
    #1;
    chk("bp_end_grant", 32'(grant), 0);

    // reset during RDRESP with rr pointer at 4
    reqData[7:0]   = 8'h05;
    reqData[39:32] = 8'h05;
    reqValid       = 5'b10001;
    cyc();
`ifdef BP_REG_ARB_FIXED_PRIO_EN
    chk("rs_cmd_grant", 32'(grant), 'h01);
`else
    chk("rs_cmd_grant", 32'(grant), 'h10);
`endif
    cyc();
    chk("rs_resp_memvalid", 32'(memValid), 0);
    rstN = 1'b0;
    #1;
    chk("rs_grant", 32'(grant), 0);
    chk("rs_memready", 32'(memRready), 0);
    chk("rs_reqready", 32'(reqReady), 0);
    cyc();
    rstN = 1'b1;
    cyc();
    chk("rs_after_grant", 32'(grant), 'h01);
    chk("rs_after_data", 32'(memData), 'h05);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
